uart_echo: RTL and testbench

UART_ECHO -- requirements
Module: uart_echo

---
 rtl/uart_echo.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_uart_echo.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo.sv
// UART loopback: receives frames on uart_rx, buffers good bytes in a small FIFO,
// and retransmits them on uart_tx with the same framing.
module uart_echo #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ    = 50,
  parameter int BPS         = 9600,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk_sys,
  input  logic                          rst,
  input  logic                          uart_rx,
  output logic                          uart_tx,
  output logic                          rx_err,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy
);

  localparam int BIT_CNT  = (CLK_FREQ * 1000000) / BPS;
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int NW       = AW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d);
    if (PARITY_TYPE != 0) begin
      f_parity = ~^d;
    end else begin
      f_parity = ^d;
    end
  endfunction

  // ---------------- receiver ----------------
  logic [1:0]            r_rx_sync;
  logic                  r_rx_prev;
  state_t                r_rx_state;
  logic [CW-1:0]         r_rx_cnt;
  logic [IW-1:0]         r_rx_idx;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_perr;
  logic                  r_rx_err;

  state_t                w_rx_state_nx;
  logic [CW-1:0]         w_rx_cnt_nx;
  logic [IW-1:0]         w_rx_idx_nx;
  logic [DATA_WIDTH-1:0] w_rx_data_nx;
  logic                  w_rx_perr_nx;
  logic                  w_rx_good;
  logic                  w_rx_bad;
  logic                  w_rx_bit;

  assign w_rx_bit = r_rx_sync[1];

  // Two-stage synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_rx_sync <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[0], uart_rx};
      r_rx_prev <= r_rx_sync[1];
    end
  end

  // Receiver next-state logic; the stop sample decides push or error
  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt + CW'(1);
    w_rx_idx_nx   = r_rx_idx;
    w_rx_data_nx  = r_rx_data;
    w_rx_perr_nx  = r_rx_perr;
    w_rx_good     = 1'b0;
    w_rx_bad      = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_nx = '0;
        if (r_rx_prev && !w_rx_bit) begin
          w_rx_state_nx = S_START;
          w_rx_perr_nx  = 1'b0;
        end else begin
          w_rx_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_idx_nx   = '0;
          w_rx_state_nx = w_rx_bit ? S_IDLE : S_DATA;
        end else begin
          w_rx_state_nx = S_START;
        end
      end
      S_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx  = '0;
          w_rx_data_nx = {w_rx_bit, r_rx_data[DATA_WIDTH-1:1]};
          if (r_rx_idx == IDX_LAST) begin
            w_rx_state_nx = (PARITY_ON != 0) ? S_PARITY : S_STOP;
          end else begin
            w_rx_idx_nx = r_rx_idx + IW'(1);
          end
        end else begin
          w_rx_state_nx = S_DATA;
        end
      end
      S_PARITY: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_perr_nx  = (w_rx_bit != f_parity(r_rx_data));
          w_rx_state_nx = S_STOP;
        end else begin
          w_rx_state_nx = S_PARITY;
        end
      end
      S_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nx   = '0;
          w_rx_state_nx = S_IDLE;
          if (w_rx_bit && !r_rx_perr) begin
            w_rx_good = 1'b1;
          end else begin
            w_rx_bad = 1'b1;
          end
        end else begin
          w_rx_state_nx = S_STOP;
        end
      end
      default: begin
        w_rx_state_nx = S_IDLE;
        w_rx_cnt_nx   = '0;
      end
    endcase
  end

  // Receiver state registers
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_idx   <= w_rx_idx_nx;
      r_rx_data  <= w_rx_data_nx;
      r_rx_perr  <= w_rx_perr_nx;
      r_rx_err   <= w_rx_bad;
    end
  end

  // ---------------- echo FIFO ----------------
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [NW-1:0]         r_count;
  logic                  r_ovf;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  state_t                r_tx_state;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_pop  = (r_tx_state == S_IDLE) && (r_count != '0);
  assign w_push = w_rx_good && ((r_count != FULL_CNT) || w_pop);
  assign w_drop = w_rx_good && (r_count == FULL_CNT) && !w_pop;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_ovf <= w_drop;
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_rx_data_nx_q();
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The received byte is complete once the last data bit has been shifted in
  function automatic logic [DATA_WIDTH-1:0] r_rx_data_nx_q();
    r_rx_data_nx_q = r_rx_data;
  endfunction

  // ---------------- transmitter ----------------
  logic [CW-1:0]         r_tx_cnt;
  logic [IW-1:0]         r_tx_idx;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_uart_tx;
  logic                  r_tx_busy;

  state_t                w_tx_state_nx;
  logic [CW-1:0]         w_tx_cnt_nx;
  logic [IW-1:0]         w_tx_idx_nx;
  logic [DATA_WIDTH-1:0] w_tx_data_nx;
  logic                  w_tx_line_nx;

  // Transmitter next state, plus the line level for that next state so
  // uart_tx can be a plain register
  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt + CW'(1);
    w_tx_idx_nx   = r_tx_idx;
    w_tx_data_nx  = r_tx_data;
    w_tx_line_nx  = 1'b1;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_cnt_nx = '0;
        w_tx_idx_nx = '0;
        if (w_pop) begin
          w_tx_state_nx = S_START;
          w_tx_data_nx  = r_mem[r_rd_ptr];
        end else begin
          w_tx_state_nx = S_IDLE;
        end
      end
      S_START: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_idx_nx   = '0;
          w_tx_state_nx = S_DATA;
        end else begin
          w_tx_state_nx = S_START;
        end
      end
      S_DATA: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx = '0;
          if (r_tx_idx == IDX_LAST) begin
            w_tx_state_nx = (PARITY_ON != 0) ? S_PARITY : S_STOP;
          end else begin
            w_tx_idx_nx = r_tx_idx + IW'(1);
          end
        end else begin
          w_tx_state_nx = S_DATA;
        end
      end
      S_PARITY: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_state_nx = S_STOP;
        end else begin
          w_tx_state_nx = S_PARITY;
        end
      end
      S_STOP: begin
        if (r_tx_cnt == BIT_LAST) begin
          w_tx_cnt_nx   = '0;
          w_tx_state_nx = S_IDLE;
        end else begin
          w_tx_state_nx = S_STOP;
        end
      end
      default: begin
        w_tx_state_nx = S_IDLE;
        w_tx_cnt_nx   = '0;
      end
    endcase
    case (w_tx_state_nx)
      S_IDLE:   w_tx_line_nx = 1'b1;
      S_START:  w_tx_line_nx = 1'b0;
      S_DATA:   w_tx_line_nx = w_tx_data_nx[w_tx_idx_nx];
      S_PARITY: w_tx_line_nx = f_parity(w_tx_data_nx);
      S_STOP:   w_tx_line_nx = 1'b1;
      default:  w_tx_line_nx = 1'b1;
    endcase
  end

  // Transmitter state and registered line outputs
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_data  <= '0;
      r_uart_tx  <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_idx   <= w_tx_idx_nx;
      r_tx_data  <= w_tx_data_nx;
      r_uart_tx  <= w_tx_line_nx;
      r_tx_busy  <= (w_tx_state_nx != S_IDLE);
    end
  end

  assign uart_tx    = r_uart_tx;
  assign tx_busy    = r_tx_busy;
  assign rx_err     = r_rx_err;
  assign overflow   = r_ovf;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_echo.sv
// Directed bench for uart_echo with BIT_CNT=10: three instances cover
// no-parity/depth 4, odd parity, and depth 2.
module tb_uart_echo;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic [2:0] rx_v;
  logic [2:0] tx_v;
  logic [2:0] busy_v;
  logic [2:0] err_v;
  logic [2:0] ovf_v;
  logic [2:0] cnt0;
  logic [2:0] cnt1;
  logic [1:0] cnt2;
  int         total = 0;
  int         bad = 0;

  always #5 clk_sys = ~clk_sys;

  uart_echo #(.DATA_WIDTH(8), .CLK_FREQ(1), .BPS(100000), .PARITY_ON(0),
              .PARITY_TYPE(0), .FIFO_DEPTH(4)) u_dut (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(rx_v[0]), .uart_tx(tx_v[0]),
    .rx_err(err_v[0]), .overflow(ovf_v[0]), .fifo_count(cnt0), .tx_busy(busy_v[0]));

  uart_echo #(.DATA_WIDTH(8), .CLK_FREQ(1), .BPS(100000), .PARITY_ON(1),
              .PARITY_TYPE(1), .FIFO_DEPTH(4)) u_par (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(rx_v[1]), .uart_tx(tx_v[1]),
    .rx_err(err_v[1]), .overflow(ovf_v[1]), .fifo_count(cnt1), .tx_busy(busy_v[1]));

  uart_echo #(.DATA_WIDTH(8), .CLK_FREQ(1), .BPS(100000), .PARITY_ON(0),
              .PARITY_TYPE(0), .FIFO_DEPTH(2)) u_d2 (
    .clk_sys(clk_sys), .rst(rst), .uart_rx(rx_v[2]), .uart_tx(tx_v[2]),
    .rx_err(err_v[2]), .overflow(ovf_v[2]), .fifo_count(cnt2), .tx_busy(busy_v[2]));

  function automatic int get_cnt(input int sel);
    case (sel)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic drive_bit(input int sel, input logic v, input int n);
    rx_v[sel] = v;
    repeat (n) @(negedge clk_sys);
  endtask

  // Must be called on a negedge; leaves the line idle-high afterwards.
  task automatic send_frame(input int sel, input logic [7:0] d, input bit has_par,
                            input logic par_bit, input logic stop_bit, input int stop_len);
    drive_bit(sel, 1'b0, 10);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], 10);
    if (has_par) drive_bit(sel, par_bit, 10);
    drive_bit(sel, stop_bit, stop_len);
    rx_v[sel] = 1'b1;
  endtask

  // Waits for a start bit, then checks every clock of every bit plus tx_busy.
  task automatic expect_frame(input int sel, input logic [7:0] d, input bit has_par,
                              input logic par_bit, input int bound, output int waited);
    logic [9:0] v;
    logic [9:0] bv;
    logic       e;
    int         nb;
    waited = 0;
    do begin
      @(negedge clk_sys);
      waited++;
    end while (tx_v[sel] === 1'b1 && waited < bound);
    total++;
    assert (tx_v[sel] === 1'b0) else begin
      bad++;
      $error("FAIL start_seen sel=%0d observed=%b expected=0 waited=%0d", sel, tx_v[sel], waited);
    end
    if (tx_v[sel] !== 1'b0) return;
    nb = has_par ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = d[b-1];
      else if (has_par && b == 9) e = par_bit;
      else e = 1'b1;
      for (int k = 0; k < 10; k++) begin
        if (b != 0 || k != 0) @(negedge clk_sys);
        v[k]  = tx_v[sel];
        bv[k] = busy_v[sel];
      end
      total++;
      assert ({v, bv} === {{10{e}}, 10'h3ff}) else begin
        bad++;
        $error("FAIL bit%0d sel=%0d observed line=%b busy=%b expected line=%b busy=1111111111",
               b, sel, v, bv, {10{e}});
      end
    end
  endtask

  task automatic watch(input int sel, input int cycles, output int errs, output int ovfs,
                       output int lows, output int maxc, output int starts);
    logic pb;
    int   c;
    errs = 0; ovfs = 0; lows = 0; maxc = 0; starts = 0;
    pb = busy_v[sel];
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_sys);
      if (err_v[sel] === 1'b1) errs++;
      if (ovf_v[sel] === 1'b1) ovfs++;
      if (tx_v[sel] === 1'b0) lows++;
      c = get_cnt(sel);
      if (c > maxc) maxc = c;
      if (busy_v[sel] === 1'b1 && pb !== 1'b1) starts++;
      pb = busy_v[sel];
    end
  endtask

  initial begin
    int w, e, o, l, m, s;
    rst  = 1'b1;
    rx_v = 3'b111;
    repeat (3) @(negedge clk_sys);

    // reset state
    total++; assert (tx_v === 3'b111) else begin bad++; $error("FAIL rst_tx observed=%b expected=111", tx_v); end
    total++; assert (busy_v === 3'b000) else begin bad++; $error("FAIL rst_busy observed=%b expected=000", busy_v); end
    total++; assert (err_v === 3'b000) else begin bad++; $error("FAIL rst_err observed=%b expected=000", err_v); end
    total++; assert (ovf_v === 3'b000) else begin bad++; $error("FAIL rst_ovf observed=%b expected=000", ovf_v); end
    total++; assert ({cnt0, cnt1, cnt2} === 8'h00) else begin bad++; $error("FAIL rst_cnt observed=%h expected=00", {cnt0, cnt1, cnt2}); end
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);

    // 0xA5 echo, no parity; start edge shortly after the RX stop sample
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 10);
      expect_frame(0, 8'hA5, 1'b0, 1'b0, 200, w);
    join
    total++; assert (w >= 97 && w <= 102) else begin bad++; $error("FAIL a5_latency observed=%0d expected=97..102", w); end
    repeat (20) @(negedge clk_sys);

    // odd parity: good frame echoed with parity 1
    fork
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 10);
      expect_frame(1, 8'h03, 1'b1, 1'b1, 250, w);
    join
    repeat (20) @(negedge clk_sys);

    // odd parity: bad parity -> one rx_err, no echo, FIFO untouched
    fork
      send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 10);
      watch(1, 150, e, o, l, m, s);
    join
    total++; assert (e === 1) else begin bad++; $error("FAIL par_err_pulses observed=%0d expected=1", e); end
    total++; assert (l === 0) else begin bad++; $error("FAIL par_no_echo observed=%0d expected=0", l); end
    total++; assert (m === 0) else begin bad++; $error("FAIL par_fifo observed=%0d expected=0", m); end
    repeat (10) @(negedge clk_sys);

    // framing error on 0x55
    fork
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, 10);
      watch(0, 150, e, o, l, m, s);
    join
    total++; assert (e === 1) else begin bad++; $error("FAIL stop_err_pulses observed=%0d expected=1", e); end
    total++; assert (l === 0 && m === 0) else begin bad++; $error("FAIL stop_no_echo observed lows=%0d cnt=%0d expected 0/0", l, m); end
    repeat (10) @(negedge clk_sys);

    // 3-clock glitch on idle line
    fork
      begin
        rx_v[0] = 1'b0;
        repeat (3) @(negedge clk_sys);
        rx_v[0] = 1'b1;
      end
      watch(0, 60, e, o, l, m, s);
    join
    total++; assert (e === 0 && l === 0 && m === 0) else begin
      bad++; $error("FAIL glitch observed err=%0d lows=%0d cnt=%0d expected 0/0/0", e, l, m);
    end
    repeat (10) @(negedge clk_sys);

    // six back-to-back frames, depth 4
    fork
      begin
        for (int k = 0; k < 6; k++) send_frame(0, 8'h10 + 8'(k), 1'b0, 1'b0, 1'b1, 10);
      end
      begin
        int wk;
        for (int k = 0; k < 6; k++) begin
          expect_frame(0, 8'h10 + 8'(k), 1'b0, 1'b0, (k == 0) ? 200 : 3, wk);
          if (k > 0) begin
            total++;
            assert (wk === 2) else begin bad++; $error("FAIL b2b_gap%0d observed=%0d expected=2", k, wk); end
          end
        end
      end
      watch(0, 700, e, o, l, m, s);
    join
    total++; assert (o === 0 && e === 0) else begin bad++; $error("FAIL b2b_ovf observed ovf=%0d err=%0d expected 0/0", o, e); end
    repeat (20) @(negedge clk_sys);

    // depth 2: RX outpaces TX using short stop bits over a long burst
    fork
      begin
        for (int k = 0; k < 100; k++) send_frame(2, 8'(k), 1'b0, 1'b0, 1'b1, 6);
      end
      watch(2, 10200, e, o, l, m, s);
    join
    total++; assert (o >= 1) else begin bad++; $error("FAIL d2_ovf_seen observed=%0d expected>=1", o); end
    total++; assert (o + s === 100) else begin bad++; $error("FAIL d2_ovf_per_drop observed=%0d expected=100 (ovf=%0d echoed=%0d)", o + s, o, s); end
    total++; assert (m === 2) else begin bad++; $error("FAIL d2_max_count observed=%0d expected=2", m); end
    total++; assert (e === 0) else begin bad++; $error("FAIL d2_rx_err observed=%0d expected=0", e); end
    repeat (20) @(negedge clk_sys);

    // reset in the middle of TX data bit 4 (0xE3 bit 4 = 0)
    fork
      send_frame(0, 8'hE3, 1'b0, 1'b0, 1'b1, 10);
      begin
        w = 0;
        do begin
          @(negedge clk_sys);
          w++;
        end while (tx_v[0] === 1'b1 && w < 200);
        total++; assert (tx_v[0] === 1'b0) else begin bad++; $error("FAIL mid_start observed=%b expected=0", tx_v[0]); end
        repeat (55) @(negedge clk_sys);
        total++; assert (tx_v[0] === 1'b0 && busy_v[0] === 1'b1) else begin
          bad++; $error("FAIL pre_rst_bit4 observed tx=%b busy=%b expected 0/1", tx_v[0], busy_v[0]);
        end
        #2 rst = 1'b1;
        #1;
        total++; assert (tx_v[0] === 1'b1) else begin bad++; $error("FAIL async_rst_tx observed=%b expected=1", tx_v[0]); end
        total++; assert (busy_v[0] === 1'b0) else begin bad++; $error("FAIL async_rst_busy observed=%b expected=0", busy_v[0]); end
        total++; assert (cnt0 === 3'd0) else begin bad++; $error("FAIL async_rst_cnt observed=%0d expected=0", cnt0); end
      end
    join
    repeat (2) @(negedge clk_sys);
    rst = 1'b0;
    repeat (5) @(negedge clk_sys);
    fork
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 10);
      expect_frame(0, 8'h3C, 1'b0, 1'b0, 200, w);
    join
    repeat (5) @(negedge clk_sys);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
